// File: rtl/ethernet_frame_check.sv
// GMII receive frame checker: preamble/SFD detection, CRC-32 residue check, length classification.
// Define ETH_FRAME_CHECK_STATS_EN to build the good/bad frame counters.
module ethernet_frame_check #(
    parameter int unsigned MIN_FRAME_LEN = 64,
    parameter int unsigned MAX_FRAME_LEN = 1518,
    parameter int unsigned MIN_PREAMBLE  = 1,
    parameter int unsigned LEN_W         = 16,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       d,
    input  logic             en,
    input  logic             er,
    input  logic             stats_clear,
    output logic             status_valid,
    output logic             crc_ok,
    output logic             runt,
    output logic             oversize,
    output logic             rx_err,
    output logic             frame_ok,
    output logic [LEN_W-1:0] frame_len,
    output logic [CNT_W-1:0] good_frames,
    output logic [CNT_W-1:0] bad_frames
);

    localparam logic [31:0]      CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN     = LEN_W'(MAX_FRAME_LEN);
    localparam logic [2:0]       MIN_PRE     = 3'(MIN_PREAMBLE);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        DATA,
        DROP
    } state_t;

    state_t           state_q;
    logic [2:0]       pre_cnt_q;
    logic [31:0]      crc_q;
    logic [31:0]      crc_d;
    logic [LEN_W-1:0] len_q;
    logic             err_q;
    logic             crc_match;
    logic             is_runt;
    logic             is_over;

    // Whole byte folded into the reflected CRC in one cycle.
    always_comb begin
        crc_d = crc_q ^ {24'd0, d};
        for (int unsigned i = 0; i < 8; i++) begin
            crc_d = crc_d[0] ? ((crc_d >> 1) ^ CRC_POLY) : (crc_d >> 1);
        end
    end

    assign crc_match = (crc_q == CRC_RESIDUE);
    assign is_runt   = (len_q < MIN_LEN);
    assign is_over   = (len_q > MAX_LEN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pre_cnt_q    <= '0;
            crc_q        <= '1;
            len_q        <= '0;
            err_q        <= 1'b0;
            status_valid <= 1'b0;
            crc_ok       <= 1'b0;
            runt         <= 1'b0;
            oversize     <= 1'b0;
            rx_err       <= 1'b0;
            frame_ok     <= 1'b0;
            frame_len    <= '0;
        end else begin
            status_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (en) begin
                        if (d == 8'h55) begin
                            state_q   <= PREAMBLE;
                            pre_cnt_q <= 3'd1;
                        end else begin
                            state_q <= DROP;
                        end
                    end
                end
                PREAMBLE: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end else if (er) begin
                        state_q <= DROP;
                    end else if (d == 8'h55) begin
                        if (pre_cnt_q != 3'd7) begin
                            pre_cnt_q <= pre_cnt_q + 3'd1;
                        end
                    end else if (d == 8'hD5 && pre_cnt_q >= MIN_PRE) begin
                        state_q <= DATA;
                        crc_q   <= '1;
                        len_q   <= '0;
                        err_q   <= 1'b0;
                    end else begin
                        state_q <= DROP;
                    end
                end
                DATA: begin
                    if (en) begin
                        crc_q <= crc_d;
                        if (len_q != '1) begin
                            len_q <= len_q + 1'b1;
                        end
                        if (er) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        state_q      <= IDLE;
                        status_valid <= 1'b1;
                        crc_ok       <= crc_match;
                        runt         <= is_runt;
                        oversize     <= is_over;
                        rx_err       <= err_q;
                        frame_ok     <= crc_match & ~is_runt & ~is_over & ~err_q;
                        frame_len    <= len_q;
                    end
                end
                DROP: begin
                    if (!en) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ETH_FRAME_CHECK_STATS_EN
    // Counters follow the registered record, so they lag the status fields by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_frames <= '0;
            bad_frames  <= '0;
        end else if (stats_clear) begin
            good_frames <= '0;
            bad_frames  <= '0;
        end else if (status_valid) begin
            if (frame_ok) begin
                if (good_frames != '1) begin
                    good_frames <= good_frames + 1'b1;
                end
            end else begin
                if (bad_frames != '1) begin
                    bad_frames <= bad_frames + 1'b1;
                end
            end
        end
    end
`else
    logic stats_clear_unused;
    assign stats_clear_unused = stats_clear;
    assign good_frames        = '0;
    assign bad_frames         = '0;
`endif

endmodule

// File: tb/tb_ethernet_frame_check.sv
// Bench for ethernet_frame_check: vector table of frames, scoreboard of expected status records,
// plus hand sequences for bad preamble, preamble error, stats clear and mid-frame reset.
module tb_ethernet_frame_check;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  d;
    logic        en;
    logic        er;
    logic        stats_clear;

    logic        status_valid, crc_ok, runt, oversize, rx_err, frame_ok;
    logic [15:0] frame_len;
    logic [31:0] good_frames, bad_frames;

    logic        status_valid3, crc_ok3, runt3, oversize3, rx_err3, frame_ok3;
    logic [15:0] frame_len3;
    logic [31:0] good_frames3, bad_frames3;

    ethernet_frame_check dut (
        .clk(clk), .reset(reset), .d(d), .en(en), .er(er), .stats_clear(stats_clear),
        .status_valid(status_valid), .crc_ok(crc_ok), .runt(runt), .oversize(oversize),
        .rx_err(rx_err), .frame_ok(frame_ok), .frame_len(frame_len),
        .good_frames(good_frames), .bad_frames(bad_frames)
    );

    ethernet_frame_check #(.MIN_PREAMBLE(3)) dut3 (
        .clk(clk), .reset(reset), .d(d), .en(en), .er(er), .stats_clear(stats_clear),
        .status_valid(status_valid3), .crc_ok(crc_ok3), .runt(runt3), .oversize(oversize3),
        .rx_err(rx_err3), .frame_ok(frame_ok3), .frame_len(frame_len3),
        .good_frames(good_frames3), .bad_frames(bad_frames3)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;       // 0: "123456789"+known FCS, 1: ramp+good FCS, 2: ramp without FCS
        int nbody;
        int npre;
        bit corrupt;
        int err_idx;
        bit e_crc;
        bit e_runt;
        bit e_ov;
        bit e_err;
        int e_len;
    } vec_t;

    typedef struct {
        bit crc_ok;
        bit runt;
        bit ov;
        bit err;
        bit ok;
        int len;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  fb[$];
    logic [7:0]  pre[$];
    vec_t        vecs[8];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int n_sv1   = 0;
    int n_sv3   = 0;
    int good_m  = 0;
    int bad_m   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic build(input int kind, input int nbody, input bit corrupt);
        logic [31:0] c;
        logic [7:0]  b;
        fb.delete();
        c = '1;
        if (kind == 0) begin
            for (int i = 0; i < 9; i++) fb.push_back(8'(49 + i));
            fb.push_back(8'h26); fb.push_back(8'h39); fb.push_back(8'hF4); fb.push_back(8'hCB);
        end else begin
            for (int i = 0; i < nbody; i++) begin
                b = 8'(i);
                fb.push_back(b);
                c = crc_upd(c, b);
            end
            if (kind == 1) begin
                c = ~c;
                fb.push_back(c[7:0]); fb.push_back(c[15:8]);
                fb.push_back(c[23:16]); fb.push_back(c[31:24]);
                if (corrupt) fb[nbody] = fb[nbody] ^ 8'h01;
            end
        end
    endtask

    task automatic set_pre(input int npre);
        pre.delete();
        for (int i = 0; i < npre; i++) pre.push_back(8'h55);
        pre.push_back(8'hD5);
    endtask

    // Drives pre[] then fb[], then an en=0 gap; er is pulsed on the first gap cycle (must be ignored).
    task automatic drive_frame(input int err_pre, input int err_idx, input bit want,
                               input exp_t e_in, input int gap);
        exp_t e;
        e = e_in;
        for (int i = 0; i < pre.size(); i++) begin
            @(posedge clk); #1;
            en = 1'b1; d = pre[i]; er = (i == err_pre);
        end
        for (int i = 0; i < fb.size(); i++) begin
            @(posedge clk); #1;
            en = 1'b1; d = fb[i]; er = (i == err_idx);
        end
        @(posedge clk); #1;
        en = 1'b0; d = 8'h00; er = 1'b1;
        if (want) begin
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        for (int g = 1; g < gap; g++) begin
            @(posedge clk); #1;
            er = 1'b0;
        end
    endtask

    function automatic exp_t mk_exp(input bit c, input bit r, input bit o, input bit er_, input int len);
        exp_t e;
        e.crc_ok = c; e.runt = r; e.ov = o; e.err = er_;
        e.ok = c & ~r & ~o & ~er_;
        e.len = len; e.cyc = 0;
        return e;
    endfunction

    always @(negedge clk) if (!reset && status_valid3) n_sv3++;

    always @(negedge clk) begin
        if (!reset && status_valid) begin
            n_sv1++;
            if (sb.size() == 0) begin
                chk("unexpected_status", status_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("status_cycle", cyc, e.cyc);
                chk("crc_ok", crc_ok, e.crc_ok);
                chk("runt", runt, e.runt);
                chk("oversize", oversize, e.ov);
                chk("rx_err", rx_err, e.err);
                chk("frame_ok", frame_ok, e.ok);
                chk("frame_len", frame_len, e.len);
`ifdef ETH_FRAME_CHECK_STATS_EN
                if (e.ok) good_m++;
                else bad_m++;
`endif
                @(negedge clk);
                chk("status_pulse", status_valid, 1'b0);
                chk("frame_len_hold", frame_len, e.len);
                chk("good_frames", good_frames, good_m);
                chk("bad_frames", bad_frames, bad_m);
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: run did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   c1, c3;

        vecs[0] = '{0, 9,    7, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 13};
        vecs[1] = '{1, 60,   7, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 64};
        vecs[2] = '{1, 60,   7, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 64};
        vecs[3] = '{1, 60,   7, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b1, 64};
        vecs[4] = '{1, 1515, 7, 1'b0, -1, 1'b1, 1'b0, 1'b1, 1'b0, 1519};
        vecs[5] = '{1, 1514, 3, 1'b0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 1518};
        vecs[6] = '{1, 59,   1, 1'b0, -1, 1'b1, 1'b1, 1'b0, 1'b0, 63};
        vecs[7] = '{2, 2,    2, 1'b0, -1, 1'b0, 1'b1, 1'b0, 1'b0, 2};

        reset = 1'b1; en = 1'b0; er = 1'b0; d = 8'h00; stats_clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {status_valid, crc_ok, runt, oversize, rx_err, frame_ok, frame_len,
                              good_frames[7:0], bad_frames[7:0]}, '0);
        chk("reset_counters", {good_frames, bad_frames}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 8; v++) begin
            c3 = n_sv3;
            build(vecs[v].kind, vecs[v].nbody, vecs[v].corrupt);
            set_pre(vecs[v].npre);
            e = mk_exp(vecs[v].e_crc, vecs[v].e_runt, vecs[v].e_ov, vecs[v].e_err, vecs[v].e_len);
            drive_frame(-1, vecs[v].err_idx, 1'b1, e, 3);
            chk("dut3_min_preamble", n_sv3 - c3, (vecs[v].npre >= 3) ? 1 : 0);
        end

        // Corrupt preamble, one idle cycle, then a good frame back-to-back.
        c1 = n_sv1;
        build(1, 60, 1'b0);
        pre.delete();
        pre.push_back(8'h55); pre.push_back(8'h55); pre.push_back(8'h5D); pre.push_back(8'hD5);
        drive_frame(-1, -1, 1'b0, e, 1);
        set_pre(7);
        drive_frame(-1, -1, 1'b1, mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 64), 3);
        chk("bad_preamble_status_count", n_sv1 - c1, 1);

        // er during preamble drops the frame.
        c1 = n_sv1;
        set_pre(3);
        drive_frame(1, -1, 1'b0, e, 3);
        chk("preamble_er_dropped", n_sv1 - c1, 0);

        // stats_clear pulse.
        @(posedge clk); #1; stats_clear = 1'b1;
        @(posedge clk); #1; stats_clear = 1'b0;
        good_m = 0; bad_m = 0;
        @(negedge clk);
        chk("stats_clear", {good_frames, bad_frames}, '0);
        chk("stats_clear_keeps_status", frame_len, 16'd64);
        drive_frame(-1, -1, 1'b1, mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 64), 3);

        // Reset at byte 20, then the remaining bytes without preamble must not report.
        c1 = n_sv1;
        for (int i = 0; i < pre.size(); i++) begin
            @(posedge clk); #1; en = 1'b1; d = pre[i]; er = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1; d = fb[i];
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midframe_reset_outputs", {status_valid, crc_ok, runt, oversize, rx_err, frame_ok,
                                       frame_len}, '0);
        chk("midframe_reset_counters", {good_frames, bad_frames}, '0);
        good_m = 0; bad_m = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 20; i < fb.size(); i++) begin
            @(posedge clk); #1; en = 1'b1; d = fb[i];
        end
        @(posedge clk); #1; en = 1'b0;
        repeat (3) @(posedge clk);
        chk("post_reset_no_status", n_sv1 - c1, 0);
        drive_frame(-1, -1, 1'b1, mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 64), 3);

        er = 1'b0;
        repeat (5) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
